// File: rtl/hiscore_upload_server.sv
// Upload side of the HPS ioctl channel: pauses the CPU and serves hiscore/NVRAM bytes from core work RAM.
// Optional HISCORE_UPLOAD_CHECKSUM_EN: a read at addr==LENGTH returns the two's complement of the byte sum.
module hiscore_upload_server #(
  parameter int          AW          = 16,
  parameter logic [AW-1:0] BASE      = '0,
  parameter int          LENGTH      = 64,
  parameter int          RAM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          save_trigger,
  input  logic          upload,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  output logic [7:0]    din,
  output logic          wait_o,
  output logic          upload_req,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_data,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_PAUSING, S_READY, S_FETCH} state_t;

  localparam int          CW    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAM_LATENCY - 1);
  localparam logic [AW:0] LEN_W = (AW+1)'(LENGTH);

  state_t        state_q, state_d;
  logic          trig_q;
  logic          upload_req_q, upload_req_d;
  logic          pause_req_q, pause_req_d;
  logic          wait_q, wait_d;
  logic          ram_rd_q, ram_rd_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]    din_q, din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          start_rd;
  logic [AW-1:0] start_addr;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      trig_q       <= 1'b0;
      upload_req_q <= 1'b0;
      pause_req_q  <= 1'b0;
      wait_q       <= 1'b0;
      ram_rd_q     <= 1'b0;
      ram_addr_q   <= '0;
      din_q        <= 8'h00;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      addr_q       <= '0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      trig_q       <= save_trigger;
      upload_req_q <= upload_req_d;
      pause_req_q  <= pause_req_d;
      wait_q       <= wait_d;
      ram_rd_q     <= ram_rd_d;
      ram_addr_q   <= ram_addr_d;
      din_q        <= din_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // NOTE: every variable gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_d      = state_q;
    upload_req_d = 1'b0;
    pause_req_d  = pause_req_q;
    wait_d       = wait_q;
    ram_rd_d     = ram_rd_q;
    ram_addr_d   = ram_addr_q;
    din_d        = din_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    start_rd     = 1'b0;
    start_addr   = addr;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (upload) begin
          state_d     = S_PAUSING;
          pause_req_d = 1'b1;
          pend_d      = 1'b0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
          sum_d       = 8'h00;
`endif
        end else if (save_trigger && !trig_q) begin
          upload_req_d = 1'b1;
        end
      end
      S_PAUSING: begin
        // A read arriving before the pause is acknowledged is parked with wait_o held high.
        if (paused) begin
          if (pend_q) begin
            start_rd   = 1'b1;
            start_addr = addr_q;
          end else if (rd) begin
            start_rd = 1'b1;
          end else begin
            state_d = S_READY;
          end
        end else if (rd && !pend_q) begin
          pend_d = 1'b1;
          addr_d = addr;
          wait_d = 1'b1;
        end
      end
      S_READY: begin
        if (rd) start_rd = 1'b1;
      end
      S_FETCH: begin
        if (cnt_q == LAST) begin
          din_d    = ram_data;
          ram_rd_d = 1'b0;
          wait_d   = 1'b0;
          state_d  = S_READY;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
          sum_d    = sum_q + ram_data;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Out-of-range bytes are presented on the accepting edge with no wait cycles.
    if (start_rd) begin
      pend_d  = 1'b0;
      state_d = S_READY;
      if ({1'b0, start_addr} < LEN_W) begin
        ram_addr_d = BASE + start_addr;
        ram_rd_d   = 1'b1;
        wait_d     = 1'b1;
        cnt_d      = '0;
        state_d    = S_FETCH;
      end else begin
        din_d  = 8'hFF;
        wait_d = 1'b0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
        if ({1'b0, start_addr} == LEN_W) din_d = 8'h00 - sum_q;
`endif
      end
    end

    // Upload dropping aborts everything; din keeps its last delivered byte.
    if (state_q != S_IDLE && !upload) begin
      state_d     = S_IDLE;
      ram_rd_d    = 1'b0;
      wait_d      = 1'b0;
      pause_req_d = 1'b0;
      pend_d      = 1'b0;
      din_d       = din_q;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_d       = sum_q;
`endif
    end
  end

  assign din        = din_q;
  assign wait_o     = wait_q;
  assign upload_req = upload_req_q;
  assign pause_req  = pause_req_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hiscore_upload_server.sv
// Directed bench for hiscore_upload_server: trigger pulse, pausing, table of reads, abort and async reset.
module tb_hiscore_upload_server;

  localparam int          AW      = 16;
  localparam logic [15:0] BASE    = 16'h0000;
  localparam int          LENGTH  = 64;
  localparam int          LAT     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_trigger, upload, rd, paused;
  logic [15:0] addr;
  logic [7:0]  din, ram_data;
  logic        wait_o, upload_req, pause_req, ram_rd, busy;
  logic [15:0] ram_addr;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  exp_din;
    int          exp_wait;
  } vec_t;
  vec_t vecs [8];

  hiscore_upload_server #(.AW(AW), .BASE(BASE), .LENGTH(LENGTH), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .save_trigger(save_trigger), .upload(upload), .rd(rd),
    .addr(addr), .din(din), .wait_o(wait_o), .upload_req(upload_req), .pause_req(pause_req),
    .paused(paused), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: one register stage, so data for an address set at edge k is valid at edge k+2.
  always @(posedge clk) ram_data <= mem[ram_addr[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one rd, then count cycles with wait_o high until the byte is delivered.
  task automatic do_read(input logic [15:0] a, output int nwait);
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0;
    nwait = 0;
    while (wait_o && nwait < 20) begin
      nwait++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  pulses;
    logic held;
    logic [7:0] chk_exp;

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    chk_exp = 8'h56;
`else
    chk_exp = 8'hFF;
`endif
    vecs[0] = '{16'd0,          8'h11,   2};
    vecs[1] = '{16'd1,          8'h22,   2};
    vecs[2] = '{16'd2,          8'h33,   2};
    vecs[3] = '{16'd3,          8'h44,   2};
    vecs[4] = '{16'(LENGTH+5),  8'hFF,   0};
    vecs[5] = '{16'(LENGTH),    chk_exp, 0};
    vecs[6] = '{16'(LENGTH-1),  8'hC3,   2};
    vecs[7] = '{16'd2,          8'h33,   2};

    foreach (mem[i]) mem[i] = 8'(i);
    mem[0] = 8'h5A;
    mem[LENGTH-1] = 8'hC3;

    reset = 1'b1; save_trigger = 1'b0; upload = 1'b0; rd = 1'b0; paused = 1'b0; addr = '0;
    tick();
    check("rst_din", din, 8'h00);
    check("rst_wait", wait_o, 0);
    check("rst_upload_req", upload_req, 0);
    check("rst_pause_req", pause_req, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Trigger edge, then a second edge three cycles later while uploading.
    save_trigger = 1'b1;
    tick();
    check("req_pulse", upload_req, 1);
    save_trigger = 1'b0;
    tick();
    check("req_width", upload_req, 0);
    upload = 1'b1;
    tick();
    save_trigger = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (upload_req) pulses++;
    end
    check("req_second_edge_dropped", pulses, 0);
    check("pause_req_uploading", pause_req, 1);
    check("busy_uploading", busy, 1);
    save_trigger = 1'b0; upload = 1'b0;
    tick();
    check("idle_after_drop", busy, 0);
    check("pause_req_after_drop", pause_req, 0);
    tick();

    // Upload rising together with a trigger edge wins.
    save_trigger = 1'b1; upload = 1'b1;
    tick();
    check("req_upload_priority", upload_req, 0);
    upload = 1'b0; save_trigger = 1'b0;
    tick();
    tick();

    // Read parked while the CPU has not yet acknowledged the pause.
    paused = 1'b0; upload = 1'b1;
    tick();
    tick();
    rd = 1'b1; addr = 16'd0;
    tick();
    rd = 1'b0;
    check("wait_while_pausing", wait_o, 1);
    held = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      held = held & wait_o;
    end
    check("wait_held_pausing", held, 1);
    paused = 1'b1;
    tick();
    n = 0;
    while (wait_o && n < 20) begin
      n++;
      tick();
    end
    check("pend_wait_cycles", n, LAT);
    check("pend_din", din, 8'h5A);

    // Fresh upload session so the running sum covers only the table bytes.
    upload = 1'b0;
    tick();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    upload = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      rd = 1'b1; addr = vecs[i].a;
      tick();
      rd = 1'b0;
      if (vecs[i].exp_wait > 0) begin
        check($sformatf("vec%0d_ram_addr", i), ram_addr, 16'(BASE + vecs[i].a));
        check($sformatf("vec%0d_ram_rd", i), ram_rd, 1);
      end
      n = 0;
      while (wait_o && n < 20) begin
        n++;
        tick();
      end
      check($sformatf("vec%0d_wait_cycles", i), n, vecs[i].exp_wait);
      check($sformatf("vec%0d_din", i), din, vecs[i].exp_din);
      check($sformatf("vec%0d_pause_req", i), pause_req, 1);
      tick();
    end

    // Abort one cycle into a fetch: outputs drop, din keeps the previous byte.
    rd = 1'b1; addr = 16'd1;
    tick();
    rd = 1'b0;
    check("abort_fetch_started", ram_rd, 1);
    upload = 1'b0;
    tick();
    check("abort_ram_rd", ram_rd, 0);
    check("abort_wait", wait_o, 0);
    check("abort_pause_req", pause_req, 0);
    check("abort_busy", busy, 0);
    check("abort_din", din, 8'h33);
    tick();
    check("abort_din_hold", din, 8'h33);

    // Asynchronous reset in the middle of a fetch.
    upload = 1'b1;
    tick();
    tick();
    rd = 1'b1; addr = 16'd3;
    tick();
    rd = 1'b0;
    check("rfetch_wait", wait_o, 1);
    #2 reset = 1'b1;
    #1;
    check("rfetch_din", din, 8'h00);
    check("rfetch_wait_clr", wait_o, 0);
    check("rfetch_ram_rd", ram_rd, 0);
    check("rfetch_ram_addr", ram_addr, 0);
    check("rfetch_pause_req", pause_req, 0);
    check("rfetch_busy", busy, 0);
    paused = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("restart_busy", busy, 1);
    check("restart_pause_req", pause_req, 1);
    tick();
    check("restart_still_pausing_wait", wait_o, 0);
    paused = 1'b1;
    tick();
    do_read(16'd0, n);
    check("restart_wait_cycles", n, LAT);
    check("restart_din", din, 8'h11);

    upload = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hiscore_upload_server.md
Name: hiscore_upload_server

Overview:
- Serves the upload direction of the HPS ioctl channel: the HPS pulls hiscore/NVRAM bytes out of the core.
- Raises an upload request on a save trigger.
- Once the upload starts, pauses the CPU and answers each HPS byte read by fetching from a fixed window of core work RAM.
- Throttles the HPS with a wait signal while each byte is fetched.
- Sits beside the hiscore/pause logic in the emu top, on clk_sys.

Parameters:
- AW, 16: width of core RAM address and ioctl byte address.
- BASE, 16'h0000: core RAM address of upload byte 0.
- LENGTH, 64: number of bytes in the upload window (1..2^AW-BASE).
- RAM_LATENCY, 2: cycles from ram_addr valid to ram_data valid (>=1).

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  asynchronous, active-high reset.
- save_trigger  in  1  request a save; acted on at the rising edge.
- upload  in  1  ioctl_upload level from HPS.
- rd  in  1  ioctl_rd single-cycle byte-read strobe.
- addr  in  AW  ioctl_addr byte offset, valid with rd.
- din  out  8  byte returned to HPS (ioctl_din).
- wait_o  out  1  ioctl_wait; HPS holds off while high.
- upload_req  out  1  one-cycle pulse to ioctl_upload_req.
- pause_req  out  1  CPU pause request.
- paused  in  1  pause acknowledged by CPU/pause block.
- ram_addr  out  AW  core RAM address.
- ram_rd  out  1  RAM read intent, high while the fetch is in flight.
- ram_data  in  8  core RAM read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: din=8'h00, wait_o=0, upload_req=0, pause_req=0, ram_addr=0, ram_rd=0, busy=0; state=IDLE; trigger edge register=0.
- save_trigger is edge-detected with one register. A rising edge seen in IDLE with upload=0 produces upload_req=1 for exactly one cycle. Edges seen in any other state, or while upload=1, are dropped.
- States:
  - IDLE: upload=1 -> PAUSING, with pause_req=1 from the next cycle.
  - PAUSING: wait for paused=1, then go to READY.
    - An rd arriving here is latched, together with addr. wait_o=1 from the next cycle until that byte is delivered.
    - With a latched read, go to FETCH when paused=1.
  - READY: on rd, latch addr.
    - addr<LENGTH: go to FETCH.
    - addr>=LENGTH: go to PRESENT with din=8'hFF.
  - FETCH:
    - ram_addr = BASE+addr, truncated to AW bits; ram_rd=1; wait_o=1, all registered on the edge that samples rd.
    - A counter runs RAM_LATENCY cycles. On the last counted edge: din<=ram_data, ram_rd<=0, wait_o<=0, return to READY.
    - With RAM_LATENCY=2: rd sampled at edge k, din valid and wait_o=0 after edge k+2.
  - PRESENT (out-of-range byte): din<=FF and wait_o stays 0 (0 cycles of wait). Return to READY on the same edge; rd is accepted again on the following cycle.
- rd while wait_o=1 is a protocol violation. It is ignored; the in-flight fetch completes unchanged.
- upload falling, in any state other than IDLE:
  - Abort: ram_rd<=0, wait_o<=0, pause_req<=0 on the next edge; go to IDLE.
  - din holds its last value.
  - A fetch aborted mid-latency does not update din.
- upload rising in the same cycle as a save_trigger edge: the upload takes priority and no upload_req pulse is issued.
- pause_req stays high from PAUSING through the end of the upload. The block never deasserts it while wait_o=1 unless aborting.
- reset asserted mid-fetch: all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: HISCORE_UPLOAD_CHECKSUM_EN.
- When defined:
  - A running 8-bit sum of every in-range byte delivered is kept; it clears on entry to PAUSING.
  - A read at addr==LENGTH returns the two's complement of that sum (0-sum) instead of FF, with 0 wait cycles.
  - addr>LENGTH still returns FF.
- When undefined: no sum register; every addr>=LENGTH returns FF.

Test Plan:
- Trigger edge, then a second edge 3 cycles later while upload=1 -> exactly one upload_req pulse, of width 1, from the first edge only.
- upload=1 with paused tied 0 for 10 cycles, rd addr=0 at cycle 2 -> wait_o high from cycle 3. Then paused=1 -> RAM[BASE]=8'h5A appears on din RAM_LATENCY cycles later with wait_o=0.
- Paused; read addrs 0..3 of RAM bytes 11,22,33,44, each rd issued one cycle after wait_o drops -> din sequence 11,22,33,44, with exactly 2 wait cycles per byte (RAM_LATENCY=2).
- rd addr=LENGTH+5 -> din=FF, wait_o never rises. With HISCORE_UPLOAD_CHECKSUM_EN, after bytes 11,22,33,44, rd addr=LENGTH -> din=8'h56.
- upload dropped 1 cycle into a fetch -> next cycle ram_rd=0, wait_o=0, pause_req=0, busy=0; din unchanged from the prior byte.
- reset pulsed during FETCH -> all outputs are 0 in the same cycle. A subsequent upload restarts from PAUSING.
